ps2_key_ctrl: RTL and testbench
===============================

Name: ps2_key_ctrl

Overview:
Keyboard front-end controller for the Whac-A-Mole game. It continuously receives PS/2 frames, validates them, and parses scan-code set 2 make/break sequences, including the E0/F0 prefixes. It tracks which of the nine numeric-keypad "mole" keys are held and delivers one press/release event per real key transition to game logic through a small valid/ready FIFO. It sits between the PS/2 pins and the game FSM, and replaces one-shot 4-byte capture with free-running, framed, back-pressured event delivery.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz.
TIMEOUT_US, 1000, partial-frame abort time in microseconds; TIMEOUT_CYC = CLK_HZ/1000000*TIMEOUT_US.
FIFO_DEPTH, 4, event FIFO entries; must be a power of 2, minimum 2.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset (asserted at 0).
ps2_clk  in  1  raw PS/2 clock pin.
ps2_data  in  1  raw PS/2 data pin.
ev_valid  out  1  FIFO head holds an event.
ev_ready  in  1  consumer accepts head; a pop occurs when ev_valid && ev_ready.
ev_key  out  4  head key index 0..8 (KP1 maps to 0, KP9 maps to 8).
ev_press  out  1  head event type: 1 = make, 0 = break.
held  out  9  bit i set while key i is held.
frame_err  out  1  one-cycle pulse when a frame is discarded for bad start, parity, stop or timeout.
ovf  out  1  sticky flag: an event was dropped because the FIFO was full.
ovf_clr  in  1  clears ovf; ovf_clr has priority over a same-cycle overflow set.

Behaviour:
- Reset (reset=0, asynchronous): ev_valid=0, ev_key=0, ev_press=0, held=0, frame_err=0, ovf=0. FIFO is emptied, parser goes to IDLE, bit counter and timeout counter are cleared, synchronizers are set to 1. Asserting reset mid-frame or mid-sequence discards everything in progress.
- Input conditioning: each of ps2_clk and ps2_data passes through a 2-FF synchronizer. A falling edge is a synced prev=1, cur=0. Data is sampled on that cycle.
- Frame receiver: collects 11 bits, LSB first (start, d0..d7, parity, stop).
  - On the 11th edge the frame is accepted only if start=0, odd parity holds over d0..d7 plus the parity bit, and stop=1. Otherwise frame_err pulses and the byte is dropped.
  - Timeout: while bit count is 1..10, a counter runs and resets on each falling edge. When it reaches TIMEOUT_CYC, the partial frame is dropped, frame_err pulses, and the bit count returns to 0.
- Parser FSM (acts on each accepted byte):
  - IDLE:
    - F0 goes to BRK.
    - E0 goes to EXT.
    - A mapped code with held[i]=0 sets held[i] and pushes (i, press=1).
    - A mapped code with held[i]=1 is typematic repeat: ignored, no push.
    - Any other byte (including E1, AA, FA) is ignored; stay in IDLE.
  - BRK: a mapped code with held[i]=1 clears held[i] and pushes (i, press=0). A mapped code with held[i]=0 is ignored. Any byte returns to IDLE.
  - EXT: F0 goes to EXT_BRK. Any other byte returns to IDLE with no event, so E0 6B (left arrow) never aliases KP4.
  - EXT_BRK: any byte returns to IDLE with no event.
- Map: 69 to 0, 72 to 1, 7A to 2, 6B to 3, 73 to 4, 74 to 5, 6C to 6, 75 to 7, 7D to 8 (hex).
- Latency: with the FIFO empty, ev_valid rises exactly 3 clk after the cycle the stop-bit falling edge is detected.
  - Stages: byte valid, then parser push, then FIFO head visible (first-word fall-through).
  - held updates in the same cycle as the push.
- FIFO rules:
  - Push while full with no same-cycle pop: event dropped, ovf set. held still updates.
  - Push while full with a same-cycle pop: push accepted, no overflow.
  - Push and pop on an empty FIFO: ev_valid goes high the next cycle with the pushed event.
  - ev_key and ev_press are stable while ev_valid=1 && ev_ready=0.
- Read and write pointers wrap modulo FIFO_DEPTH. The count width is log2(FIFO_DEPTH)+1.

Test Plan:
- Send frame 0x73 (KP5) with ev_ready=1 -> ev_valid high 3 clk after stop edge, ev_key=4, ev_press=1, held=9'h010; then send F0 73 -> one event (4, press=0), held=0.
- Send 6B, 6B, 6B (typematic) then F0 6B -> exactly two events, (3,1) then (3,0).
- Send E0 6B then E0 F0 6B -> no events, held stays 0, parser back in IDLE (a following 69 yields (0,1)).
- Send frame 0x75 with parity bit flipped -> frame_err pulses once, no event. Send 5 bits then idle TIMEOUT_CYC+1 cycles -> frame_err pulse. Then a valid 0x7D -> (8,1).
- Hold ev_ready=0 and send makes for keys 0..4 (FIFO_DEPTH=4) -> first 4 events retained in order, ovf=1, held=9'h01F. Pulse ovf_clr -> ovf=0. Drain yields keys 0,1,2,3.
- Drop reset to 0 between bit 6 and bit 7 of a frame while 2 events are queued -> ev_valid=0 and held=0 immediately. After release, a clean 0x72 yields (1,1).

Source files
------------

// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard front-end: framed receiver, scan-code set 2 parser for the nine
// keypad mole keys, and a valid/ready event FIFO with a sticky overflow flag.
module ps2_key_ctrl #(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned TIMEOUT_US = 1000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [3:0] ev_key,
    output logic       ev_press,
    output logic [8:0] held,
    output logic       frame_err,
    output logic       ovf,
    input  logic       ovf_clr
);

    localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
    localparam int unsigned TW          = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned PW          = $clog2(FIFO_DEPTH);
    localparam int unsigned CW          = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

    logic [2:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    dat_sync_q, dat_sync_d;
    logic [9:0]    shift_q, shift_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          byte_vld_q, byte_vld_d;
    logic [7:0]    byte_q, byte_d;
    logic          frame_err_q, frame_err_d;
    state_t        state_q, state_d;
    logic [8:0]    held_q, held_d;
    logic          push_q, push_d;
    logic [3:0]    push_key_q, push_key_d;
    logic          push_press_q, push_press_d;
    logic [4:0]    mem_q [FIFO_DEPTH];
    logic [4:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          ev_valid_q, ev_valid_d;
    logic [3:0]    ev_key_q, ev_key_d;
    logic          ev_press_q, ev_press_d;
    logic          ovf_q, ovf_d;

    logic          fall_c, pop_c, full_c, push_ok_c;
    logic [10:0]   frame_c;
    logic [4:0]    map_c, head_c;

    // Keypad scan code -> {hit, key index}
    function automatic logic [4:0] map_code(input logic [7:0] c);
        case (c)
            8'h69:   map_code = {1'b1, 4'd0};
            8'h72:   map_code = {1'b1, 4'd1};
            8'h7A:   map_code = {1'b1, 4'd2};
            8'h6B:   map_code = {1'b1, 4'd3};
            8'h73:   map_code = {1'b1, 4'd4};
            8'h74:   map_code = {1'b1, 4'd5};
            8'h6C:   map_code = {1'b1, 4'd6};
            8'h75:   map_code = {1'b1, 4'd7};
            8'h7D:   map_code = {1'b1, 4'd8};
            default: map_code = 5'd0;
        endcase
    endfunction

    // Synchronizers and frame receiver; bit 1 of each sync chain is the synced level
    always_comb begin
        clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
        dat_sync_d  = {dat_sync_q[0], ps2_data};
        fall_c      = clk_sync_q[2] & ~clk_sync_q[1];
        frame_c     = {dat_sync_q[1], shift_q};
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        to_cnt_d    = '0;
        byte_vld_d  = 1'b0;
        byte_d      = byte_q;
        frame_err_d = 1'b0;
        if (fall_c) begin
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = '0;
                if (!frame_c[0] && (^frame_c[9:1]) && frame_c[10]) begin
                    byte_vld_d = 1'b1;
                    byte_d     = frame_c[8:1];
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                shift_d   = {dat_sync_q[1], shift_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                bit_cnt_d   = '0;
                frame_err_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end
    end

    // Make/break parser; E0-prefixed codes never produce events
    always_comb begin
        state_d      = state_q;
        held_d       = held_q;
        push_d       = 1'b0;
        push_key_d   = push_key_q;
        push_press_d = push_press_q;
        map_c        = map_code(byte_q);
        if (byte_vld_q) begin
            case (state_q)
                S_IDLE: begin
                    if (byte_q == 8'hF0) begin
                        state_d = S_BRK;
                    end else if (byte_q == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (map_c[4] && !held_q[map_c[3:0]]) begin
                        held_d[map_c[3:0]] = 1'b1;
                        push_d       = 1'b1;
                        push_key_d   = map_c[3:0];
                        push_press_d = 1'b1;
                    end
                end
                S_BRK: begin
                    state_d = S_IDLE;
                    if (map_c[4] && held_q[map_c[3:0]]) begin
                        held_d[map_c[3:0]] = 1'b0;
                        push_d       = 1'b1;
                        push_key_d   = map_c[3:0];
                        push_press_d = 1'b0;
                    end
                end
                S_EXT:   state_d = (byte_q == 8'hF0) ? S_EXT_BRK : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Event FIFO; head outputs are registered from the next-state memory view
    always_comb begin
        pop_c     = ev_valid_q & ev_ready;
        full_c    = (count_q == CW'(FIFO_DEPTH));
        push_ok_c = push_q & (~full_c | pop_c);
        mem_d     = mem_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        if (push_ok_c) begin
            mem_d[wr_q] = {push_press_q, push_key_q};
            wr_d        = wr_q + PW'(1);
        end
        if (pop_c) begin
            rd_d = rd_q + PW'(1);
        end
        count_d    = count_q + CW'(push_ok_c) - CW'(pop_c);
        head_c     = mem_d[rd_d];
        ev_valid_d = (count_d != '0);
        ev_key_d   = head_c[3:0];
        ev_press_d = head_c[4];
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end else if (push_q && full_c && !pop_c) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync_q   <= '1;
            dat_sync_q   <= '1;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            to_cnt_q     <= '0;
            byte_vld_q   <= 1'b0;
            byte_q       <= '0;
            frame_err_q  <= 1'b0;
            state_q      <= S_IDLE;
            held_q       <= '0;
            push_q       <= 1'b0;
            push_key_q   <= '0;
            push_press_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            count_q      <= '0;
            ev_valid_q   <= 1'b0;
            ev_key_q     <= '0;
            ev_press_q   <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            dat_sync_q   <= dat_sync_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            to_cnt_q     <= to_cnt_d;
            byte_vld_q   <= byte_vld_d;
            byte_q       <= byte_d;
            frame_err_q  <= frame_err_d;
            state_q      <= state_d;
            held_q       <= held_d;
            push_q       <= push_d;
            push_key_q   <= push_key_d;
            push_press_q <= push_press_d;
            mem_q        <= mem_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            count_q      <= count_d;
            ev_valid_q   <= ev_valid_d;
            ev_key_q     <= ev_key_d;
            ev_press_q   <= ev_press_d;
            ovf_q        <= ovf_d;
        end
    end

    assign ev_valid  = ev_valid_q;
    assign ev_key    = ev_key_q;
    assign ev_press  = ev_press_q;
    assign held      = held_q;
    assign frame_err = frame_err_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: bit-banged PS/2 frames with hand-computed
// event, held-mask, latency, error and overflow expectations.
module tb_ps2_key_ctrl;

    localparam int unsigned HALF        = 8;
    localparam int unsigned TIMEOUT_CYC = 50;

    logic       clk = 1'b0;
    logic       reset, ps2_clk, ps2_data, ev_ready, ovf_clr;
    logic       ev_valid, ev_press, frame_err, ovf;
    logic [3:0] ev_key;
    logic [8:0] held;

    int checks = 0;
    int failures = 0;
    int ferr_cnt = 0;
    logic [4:0] evq[$];
    logic lat_v4, lat_v5, lat_press;
    logic [3:0] lat_key;

    ps2_key_ctrl #(.CLK_HZ(1000000), .TIMEOUT_US(50), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_key(ev_key), .ev_press(ev_press),
        .held(held), .frame_err(frame_err), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Record every pop as {key, press} and count frame_err pulses
    always @(negedge clk) begin
        if (reset && ev_valid && ev_ready) evq.push_back({ev_key, ev_press});
        if (frame_err) ferr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ev_at(input int i);
        if (i < evq.size()) return 32'(evq[i]);
        return 32'h1F;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends the first nbits of a frame; samples DUT 4 and 5 clocks after the last falling edge
    task automatic send_frame(input logic [7:0] b, input logic flip, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            idle(HALF);
            ps2_clk = 1'b0;
            for (int k = 1; k <= HALF; k++) begin
                @(posedge clk);
                #1;
                if (k == 4) lat_v4 = ev_valid;
                if (k == 5) begin
                    lat_v5    = ev_valid;
                    lat_key   = ev_key;
                    lat_press = ev_press;
                end
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        idle(HALF);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 11);
    endtask

    initial begin
        reset = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; ev_ready = 1'b1; ovf_clr = 1'b0;
        idle(3);
        chk("rst_valid", 32'(ev_valid), 32'h0);
        chk("rst_key", 32'(ev_key), 32'h0);
        chk("rst_press", 32'(ev_press), 32'h0);
        chk("rst_held", 32'(held), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        reset = 1'b1;
        idle(4);

        // KP5 make: latency and head contents
        send(8'h73);
        chk("lat_v4", 32'(lat_v4), 32'h0);
        chk("lat_v5", 32'(lat_v5), 32'h1);
        chk("lat_key", 32'(lat_key), 32'h4);
        chk("lat_press", 32'(lat_press), 32'h1);
        chk("kp5_held", 32'(held), 32'h010);
        send(8'hF0); send(8'h73);
        chk("kp5_nev", 32'(evq.size()), 32'd2);
        chk("kp5_ev0", ev_at(0), 32'h09);
        chk("kp5_ev1", ev_at(1), 32'h08);
        chk("kp5_rel_held", 32'(held), 32'h0);
        evq.delete();

        // Typematic repeat
        send(8'h6B); send(8'h6B); send(8'h6B);
        chk("typ_held", 32'(held), 32'h008);
        send(8'hF0); send(8'h6B);
        chk("typ_nev", 32'(evq.size()), 32'd2);
        chk("typ_ev0", ev_at(0), 32'h07);
        chk("typ_ev1", ev_at(1), 32'h06);
        chk("typ_held0", 32'(held), 32'h0);
        evq.delete();

        // Extended codes never alias keypad keys
        send(8'hE0); send(8'h6B); send(8'hE0); send(8'hF0); send(8'h6B);
        chk("ext_nev", 32'(evq.size()), 32'd0);
        chk("ext_held", 32'(held), 32'h0);
        send(8'h69);
        chk("ext_next_nev", 32'(evq.size()), 32'd1);
        chk("ext_next_ev", ev_at(0), 32'h01);
        chk("ext_next_held", 32'(held), 32'h001);
        send(8'hF0); send(8'h69);
        chk("ext_rel_held", 32'(held), 32'h0);
        chk("ferr_none", 32'(ferr_cnt), 32'd0);
        evq.delete();

        // Bad parity, then timeout, then a clean frame
        send_frame(8'h75, 1'b1, 11);
        chk("par_ferr", 32'(ferr_cnt), 32'd1);
        chk("par_nev", 32'(evq.size()), 32'd0);
        chk("par_held", 32'(held), 32'h0);
        send_frame(8'h75, 1'b0, 5);
        idle(TIMEOUT_CYC + 5);
        chk("to_ferr", 32'(ferr_cnt), 32'd2);
        send(8'h7D);
        chk("to_next_nev", 32'(evq.size()), 32'd1);
        chk("to_next_ev", ev_at(0), 32'h11);
        chk("to_next_held", 32'(held), 32'h100);
        chk("to_next_ferr", 32'(ferr_cnt), 32'd2);
        send(8'hF0); send(8'h7D);
        chk("to_rel_held", 32'(held), 32'h0);
        evq.delete();

        // Overflow with consumer stalled
        ev_ready = 1'b0;
        send(8'h69); send(8'h72); send(8'h7A); send(8'h6B); send(8'h73);
        chk("ovf_flag", 32'(ovf), 32'h1);
        chk("ovf_held", 32'(held), 32'h01F);
        chk("ovf_valid", 32'(ev_valid), 32'h1);
        chk("ovf_head_key", 32'(ev_key), 32'h0);
        chk("ovf_head_press", 32'(ev_press), 32'h1);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        idle(2);
        chk("ovf_clr", 32'(ovf), 32'h0);
        chk("stall_key", 32'(ev_key), 32'h0);
        ev_ready = 1'b1;
        idle(8);
        chk("drain_nev", 32'(evq.size()), 32'd4);
        chk("drain_ev0", ev_at(0), 32'h01);
        chk("drain_ev1", ev_at(1), 32'h03);
        chk("drain_ev2", ev_at(2), 32'h05);
        chk("drain_ev3", ev_at(3), 32'h07);
        chk("drain_valid", 32'(ev_valid), 32'h0);
        evq.delete();

        // Reset mid-frame with two events queued
        ev_ready = 1'b0;
        send(8'hF0); send(8'h69); send(8'hF0); send(8'h72);
        chk("pre_rst_valid", 32'(ev_valid), 32'h1);
        chk("pre_rst_held", 32'(held), 32'h01C);
        send_frame(8'h7A, 1'b0, 7);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ev_valid), 32'h0);
        chk("mid_rst_held", 32'(held), 32'h0);
        idle(3);
        reset = 1'b1;
        ev_ready = 1'b1;
        idle(4);
        evq.delete();
        send(8'h72);
        chk("post_rst_nev", 32'(evq.size()), 32'd1);
        chk("post_rst_ev", ev_at(0), 32'h03);
        chk("post_rst_held", 32'(held), 32'h002);
        chk("post_rst_ferr", 32'(ferr_cnt), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
